// File: rtl/led_pkg.sv
// Shared mode encodings and direction type for the LED pattern engine.
package led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_COUNT   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SCAN    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd2;
    localparam logic [MODE_W-1:0] MODE_OFF     = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Programmable step prescaler: one-cycle step pulse every div_i+1 enabled cycles.
module led_prescaler #(
    parameter int PRESC_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               step_o
);

    logic [PRESC_W-1:0] presc;

    // >= rather than == so that lowering div_i below the running count fires at once.
    assign step_o = en_i && (presc >= div_i);

    // NOTE: registers use non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (en_i) begin
            presc <= step_o ? '0 : presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: binary count, bounce scan, PWM breathing and off,
// stepped by a programmable prescaler with step-aligned mode changes.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int PRESC_W = 12,
    parameter int PWM_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] div_i,
    input  logic [MODE_W-1:0]  mode_i,
    input  logic               mode_we_i,
    output logic [MODE_W-1:0]  mode_o,
    output logic               tick_o,
    output logic [NCH-1:0]     led_o
);

    localparam int                 POS_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(NCH - 1);
    localparam logic [PWM_W-1:0]   LEVEL_MAX = '1;

    logic               step;
    logic               pend_valid;
    logic [MODE_W-1:0]  pend_mode;
    logic               apply_valid;
    logic [MODE_W-1:0]  apply_mode;
    logic               reinit;
    logic               advance;

    logic [NCH-1:0]     cnt;
    logic [POS_W-1:0]   pos;
    dir_e               scan_dir;
    logic [PWM_W-1:0]   level;
    dir_e               breathe_dir;
    logic [PWM_W-1:0]   pwm;
    logic [NCH-1:0]     led_next;

    led_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .div_i  (div_i),
        .step_o (step)
    );

    // A strobe landing on the step cycle bypasses the pending slot and applies at that step.
    assign apply_valid = mode_we_i | pend_valid;
    assign apply_mode  = mode_we_i ? mode_i : pend_mode;
    assign reinit      = step && apply_valid;
    assign advance     = step && !apply_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_o     <= MODE_COUNT;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_COUNT;
        end else if (reinit) begin
            mode_o     <= apply_mode;
            pend_valid <= 1'b0;
        end else if (mode_we_i) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pos         <= '0;
            scan_dir    <= DIR_UP;
            level       <= '0;
            breathe_dir <= DIR_UP;
        end else if (reinit) begin
            case (apply_mode)
                MODE_COUNT: cnt <= '0;
                MODE_SCAN: begin
                    pos      <= '0;
                    scan_dir <= DIR_UP;
                end
                MODE_BREATHE: begin
                    level       <= '0;
                    breathe_dir <= DIR_UP;
                end
                default: ;
            endcase
        end else if (advance) begin
            case (mode_o)
                MODE_COUNT: cnt <= cnt + NCH'(1);
                MODE_SCAN: begin
                    // Ends reverse immediately so neither end position is shown twice.
                    if (NCH > 1) begin
                        if (scan_dir == DIR_UP) begin
                            if (pos == POS_LAST) begin
                                pos      <= pos - POS_W'(1);
                                scan_dir <= DIR_DOWN;
                            end else begin
                                pos <= pos + POS_W'(1);
                            end
                        end else if (pos == '0) begin
                            pos      <= pos + POS_W'(1);
                            scan_dir <= DIR_UP;
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (breathe_dir == DIR_UP) begin
                        if (level == LEVEL_MAX) begin
                            level       <= level - PWM_W'(1);
                            breathe_dir <= DIR_DOWN;
                        end else begin
                            level <= level + PWM_W'(1);
                        end
                    end else if (level == '0) begin
                        level       <= level + PWM_W'(1);
                        breathe_dir <= DIR_UP;
                    end else begin
                        level <= level - PWM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: default assigned first so every path drives led_next and no latch is inferred.
    always_comb begin
        led_next = '0;
        case (mode_o)
            MODE_COUNT:   led_next = cnt;
            MODE_SCAN:    led_next = NCH'(1) << pos;
            MODE_BREATHE: led_next = {NCH{pwm < level}};
            default:      led_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm    <= '0;
            tick_o <= 1'b0;
            led_o  <= '0;
        end else begin
            tick_o <= step;
            if (en_i) begin
                pwm <= pwm + PWM_W'(1);
            end
            led_o <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a step-count based reference model.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int NCH     = 8;
    localparam int PRESC_W = 12;
    localparam int PWM_W   = 4;
    localparam int LMAX    = (1 << PWM_W) - 1;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               en_i      = 1'b0;
    logic [PRESC_W-1:0] div_i     = '0;
    logic [1:0]         mode_i    = MODE_COUNT;
    logic               mode_we_i = 1'b0;
    logic [1:0]         mode_o;
    logic               tick_o;
    logic [NCH-1:0]     led_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NCH     (NCH),
        .PRESC_W (PRESC_W),
        .PWM_W   (PWM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .div_i     (div_i),
        .mode_i    (mode_i),
        .mode_we_i (mode_we_i),
        .mode_o    (mode_o),
        .tick_o    (tick_o),
        .led_o     (led_o)
    );

    // Reference model: pattern is a pure function of steps taken since the mode was applied.
    int             m_presc, m_pwm, m_k, m_k_shown;
    logic [1:0]     m_mode, m_mode_shown, m_pend;
    logic           m_pend_v, m_tick, m_fire;
    logic [NCH-1:0] m_led;

    function automatic int breathe_level(int k);
        int p;
        p = k % (2 * LMAX);
        return (p <= LMAX) ? p : 2 * LMAX - p;
    endfunction

    function automatic logic [NCH-1:0] expect_led(logic [1:0] md, int k, int pwm);
        int p;
        case (md)
            MODE_COUNT: return NCH'(k % (1 << NCH));
            MODE_SCAN: begin
                if (NCH == 1) return NCH'(1);
                p = k % (2 * (NCH - 1));
                return NCH'(1) << ((p < NCH) ? p : 2 * (NCH - 1) - p);
            end
            MODE_BREATHE: return (pwm < breathe_level(k)) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    assign m_fire = en_i && (m_presc >= int'(div_i));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc <= 0; m_pwm <= 0; m_k <= 0; m_k_shown <= 0;
            m_mode <= MODE_COUNT; m_mode_shown <= MODE_COUNT;
            m_pend <= MODE_COUNT; m_pend_v <= 1'b0; m_tick <= 1'b0; m_led <= '0;
        end else begin
            m_tick <= m_fire;
            if (en_i) begin
                m_presc <= m_fire ? 0 : m_presc + 1;
                m_pwm   <= (m_pwm + 1) % (1 << PWM_W);
            end
            if (m_fire) begin
                if (mode_we_i || m_pend_v) begin
                    m_mode   <= mode_we_i ? mode_i : m_pend;
                    m_k      <= 0;
                    m_pend_v <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (mode_we_i) begin
                m_pend_v <= 1'b1;
                m_pend   <= mode_i;
            end
            m_led        <= expect_led(m_mode, m_k, m_pwm);
            m_k_shown    <= m_k;
            m_mode_shown <= m_mode;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (led_o !== '0) begin errors++; $display("FAIL reset_led got %h want 0", led_o); end
        checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick_o); end
        checks++; if (mode_o !== MODE_COUNT) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_o); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        int ticks = 0;
        bit saw_wrap = 0;
        logic [NCH-1:0] prev = '0;
        en_i = 1'b1; div_i = 3;
        for (int i = 1; i <= 1040; i++) begin
            prev = led_o;
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode) begin
                errors++;
                $display("FAIL count_model t=%0t led %h want %h tick %b want %b", $time, led_o, m_led, tick_o, m_tick);
            end
            if (tick_o === 1'b1) ticks++;
            if (prev == '1 && led_o == '0) saw_wrap = 1;
        end
        checks++; if (ticks != 260) begin errors++; $display("FAIL count_ticks got %0d want 260", ticks); end
        checks++; if (led_o !== NCH'(259 % 256)) begin errors++; $display("FAIL count_final got %0d want 3", led_o); end
        checks++; if (!saw_wrap) begin errors++; $display("FAIL count_wrap got 0 want 1"); end
    endtask

    task automatic test_scan();
        div_i = 0; mode_i = MODE_SCAN; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        checks++; if (mode_o !== MODE_SCAN) begin errors++; $display("FAIL scan_mode got %0d want 1", mode_o); end
        cyc();
        checks++; if (led_o !== NCH'(1)) begin errors++; $display("FAIL scan_start got %b want 1", led_o); end
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode || !$onehot(led_o)) begin
                errors++;
                $display("FAIL scan_model t=%0t led %b want %b", $time, led_o, m_led);
            end
        end
    endtask

    task automatic test_breathe();
        int ones [0:31];
        bit found = 0;
        foreach (ones[i]) ones[i] = 0;
        div_i = 15; mode_i = MODE_BREATHE; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mode_o === MODE_BREATHE) found = 1;
            else cyc();
        end
        checks++; if (!found) begin errors++; $display("FAIL breathe_apply got mode %0d want 2", mode_o); end
        for (int i = 0; i < 31 * 16 + 32; i++) begin
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode || (led_o != '0 && led_o != '1)) begin
                errors++;
                $display("FAIL breathe_model t=%0t led %b want %b", $time, led_o, m_led);
            end
            if (m_mode_shown == MODE_BREATHE && m_k_shown < 32) ones[m_k_shown] += int'(led_o[0]);
        end
        checks++; if (ones[5]  != 5)  begin errors++; $display("FAIL breathe_up5 got %0d want 5", ones[5]); end
        checks++; if (ones[25] != 5)  begin errors++; $display("FAIL breathe_down5 got %0d want 5", ones[25]); end
        checks++; if (ones[0]  != 0)  begin errors++; $display("FAIL breathe_zero got %0d want 0", ones[0]); end
        checks++; if (ones[30] != 0)  begin errors++; $display("FAIL breathe_zero2 got %0d want 0", ones[30]); end
        checks++; if (ones[15] != 15) begin errors++; $display("FAIL breathe_max got %0d want 15", ones[15]); end
    endtask

    task automatic test_mode_strobe();
        int d;
        bit found;
        d = $urandom_range(4, 12);
        div_i = PRESC_W'(d);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (tick_o === 1'b1) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL strobe_sync got no tick want tick"); end
        // Strobe in mid-period: held until the next step.
        cyc(); cyc();
        mode_i = MODE_SCAN; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        for (int i = 0; i < d - 3; i++) begin
            cyc();
            checks++; if (mode_o !== MODE_BREATHE) begin errors++; $display("FAIL strobe_hold got %0d want 2", mode_o); end
        end
        cyc();
        checks++; if (tick_o !== 1'b1 || mode_o !== MODE_SCAN) begin errors++; $display("FAIL strobe_apply tick %b mode %0d want 1 1", tick_o, mode_o); end
        cyc();
        checks++; if (led_o !== NCH'(1)) begin errors++; $display("FAIL strobe_pos0 got %b want 1", led_o); end
        // Two strobes before the step: the later one wins.
        mode_i = MODE_SCAN; mode_we_i = 1'b1; cyc();
        mode_we_i = 1'b0; cyc();
        mode_i = MODE_OFF; mode_we_i = 1'b1; cyc();
        mode_we_i = 1'b0;
        found = 0;
        for (int i = 0; i < d + 2 && !found; i++) begin
            cyc();
            if (tick_o === 1'b1) found = 1;
        end
        checks++; if (!found || mode_o !== MODE_OFF) begin errors++; $display("FAIL strobe_last got %0d want 3", mode_o); end
        cyc();
        checks++; if (led_o !== '0) begin errors++; $display("FAIL strobe_off got %b want 0", led_o); end
        // Strobe on the step cycle itself.
        repeat (d - 1) cyc();
        mode_i = MODE_COUNT; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        checks++; if (tick_o !== 1'b1 || mode_o !== MODE_COUNT) begin errors++; $display("FAIL strobe_ontick tick %b mode %0d want 1 0", tick_o, mode_o); end
        cyc();
        checks++; if (led_o !== '0) begin errors++; $display("FAIL strobe_cnt0 got %0d want 0", led_o); end
        for (int i = 0; i < 3 * (d + 1); i++) begin
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode) begin
                errors++;
                $display("FAIL strobe_model t=%0t led %h want %h", $time, led_o, m_led);
            end
        end
    endtask

    task automatic test_div_change();
        bit found = 0;
        logic [NCH-1:0] saved;
        div_i = 100;
        for (int i = 0; i < 120 && !found; i++) begin
            cyc();
            if (tick_o === 1'b1) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL div_sync got no tick want tick"); end
        repeat (50) cyc();
        div_i = 2;
        cyc();
        checks++; if (tick_o !== 1'b1) begin errors++; $display("FAIL div_lower got %b want 1", tick_o); end
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++; if (tick_o !== (i % 3 == 2)) begin errors++; $display("FAIL div_period i=%0d got %b want %b", i, tick_o, (i % 3 == 2)); end
        end
        en_i = 1'b0;
        cyc();
        saved = led_o;
        checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL freeze_tick got %b want 0", tick_o); end
        for (int i = 0; i < 9; i++) begin
            cyc();
            checks++; if (led_o !== saved || tick_o !== 1'b0) begin errors++; $display("FAIL freeze led %h want %h tick %b want 0", led_o, saved, tick_o); end
        end
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (tick_o !== (i == 2)) begin errors++; $display("FAIL resume_tick i=%0d got %b want %b", i, tick_o, (i == 2)); end
        end
        cyc();
        checks++; if (led_o !== saved + NCH'(1)) begin errors++; $display("FAIL resume_led got %h want %h", led_o, saved + NCH'(1)); end
    endtask

    task automatic test_reset_mid();
        div_i = PRESC_W'($urandom_range(0, 3));
        mode_i = MODE_BREATHE; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode) begin
                errors++;
                $display("FAIL rmid_model t=%0t led %h want %h", $time, led_o, m_led);
            end
        end
        checks++; if (mode_o !== MODE_BREATHE) begin errors++; $display("FAIL rmid_mode got %0d want 2", mode_o); end
        en_i = 1'b0;
        mode_i = MODE_SCAN; mode_we_i = 1'b1;
        cyc();
        mode_we_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (led_o !== '0 || mode_o !== MODE_COUNT || tick_o !== 1'b0) begin
            errors++; $display("FAIL rmid_async led %h mode %0d tick %b want 0 0 0", led_o, mode_o, tick_o);
        end
        cyc();
        rst_n = 1'b1; en_i = 1'b1; div_i = 1;
        cyc(); cyc();
        checks++; if (tick_o !== 1'b1 || led_o !== '0) begin errors++; $display("FAIL rmid_restart tick %b led %h want 1 0", tick_o, led_o); end
        cyc();
        checks++; if (led_o !== NCH'(1) || mode_o !== MODE_COUNT) begin errors++; $display("FAIL rmid_cnt led %h mode %0d want 1 0", led_o, mode_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) div_i = PRESC_W'($urandom_range(0, 6));
            mode_we_i = ($urandom_range(0, 15) == 0);
            mode_i = 2'($urandom_range(0, 3));
            cyc();
            checks++;
            if (led_o !== m_led || tick_o !== m_tick || mode_o !== m_mode) begin
                errors++;
                $display("FAIL random_model t=%0t led %h want %h tick %b want %b mode %0d want %0d",
                         $time, led_o, m_led, tick_o, m_tick, mode_o, m_mode);
            end
        end
        mode_we_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_scan();
        test_breathe();
        test_mode_strobe();
        test_div_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
